// File: rtl/image_binarize_adaptive_pkg.sv
// ============================================================================
// img_pkg : shared encodings for the adaptive gray/binarize front end
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package img_pkg;

  localparam logic [1:0] MODE_GRAY  = 2'd0;
  localparam logic [1:0] MODE_FIX   = 2'd1;
  localparam logic [1:0] MODE_ADAPT = 2'd2;

  // BT.601 luma weights normalised to 2**8 and 2**10
  localparam int BT601_S8_R  = 77;
  localparam int BT601_S8_G  = 150;
  localparam int BT601_S8_B  = 29;
  localparam int BT601_S10_R = 306;
  localparam int BT601_S10_G = 601;
  localparam int BT601_S10_B = 117;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    CLAMP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/image_binarize_adaptive_seq_udiv.sv
// ============================================================================
// seq_udiv : restoring unsigned divider, one quotient bit per cycle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seq_udiv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W:0]    w_rem_sh;
  logic [W:0]    w_diff;
  logic          w_ge;
  logic          w_unused;

  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom
  always_comb begin
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    w_rem_sh = {rem_q, dvd_q[W-1]};
    w_diff   = w_rem_sh - {1'b0, dvs_q};
    w_ge     = (w_rem_sh >= {1'b0, dvs_q});
    if (busy_q) begin
      rem_d = w_ge ? w_diff[W-1:0] : w_rem_sh[W-1:0];
      dvd_d = {dvd_q[W-2:0], w_ge};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start) begin
      dvd_d  = dividend;
      dvs_d  = divisor;
      rem_d  = '0;
      cnt_d  = CW'(W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign w_unused = w_diff[W];
  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = dvd_q;

endmodule

`default_nettype wire

// File: rtl/image_binarize_adaptive.sv
// ============================================================================
// image_binarize_adaptive : 3-stage RGB->gray with gray/fixed/adaptive binarize
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module image_binarize_adaptive
  import img_pkg::*;
#(
  parameter int CH_W       = 8,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int COEF_R     = BT601_S8_R,
  parameter int COEF_G     = BT601_S8_G,
  parameter int COEF_B     = BT601_S8_B,
  parameter int GRAY_SHIFT = 8,
  parameter int FIX_THRESH = 40,
  parameter int THR_MIN    = 16,
  parameter int THR_MAX    = 240,
  parameter int ACC_W      = 32,
  parameter int VS_POL     = 1
) (
  input  logic                   clk_Image_Process,
  input  logic                   Rst,
  input  logic [1:0]             Mode,
  input  logic                   Invert,
  input  logic signed [CH_W:0]   Thr_Offset,
  input  logic [3*CH_W-1:0]      RGB_Data_Src,
  input  logic                   RGB_HSync_Src,
  input  logic                   RGB_VSync_Src,
  input  logic                   RGB_VDE_Src,
  input  logic [X_W-1:0]         RGB_x_Src,
  input  logic [Y_W-1:0]         RGB_y_Src,
  output logic [3*CH_W-1:0]      RGB_Data,
  output logic                   RGB_HSync,
  output logic                   RGB_VSync,
  output logic                   RGB_VDE,
  output logic [X_W-1:0]         RGB_x,
  output logic [Y_W-1:0]         RGB_y,
  output logic [CH_W-1:0]        Thresh_Cur,
  output logic                   Acc_Sat
);

  localparam int  PW      = CH_W + GRAY_SHIFT + 1;
  localparam int  SW      = PW + 2;
  localparam int  TW      = CH_W + 2;
  localparam int  SBW     = X_W + Y_W + 3;
  localparam int  VDE_BIT = X_W + Y_W;
  localparam int  VS_BIT  = X_W + Y_W + 1;
  localparam int  HS_BIT  = X_W + Y_W + 2;
  localparam logic VS_ACT = (VS_POL != 0);
  localparam logic [SBW-1:0]  SB_RST  = {1'b0, ~VS_ACT, {(SBW-2){1'b0}}};
  localparam logic [CH_W-1:0] THR_FIX = CH_W'(FIX_THRESH);

  logic [PW-1:0]         prod_r_q, prod_r_d, prod_g_q, prod_g_d, prod_b_q, prod_b_d;
  logic [SBW-1:0]        sb1_q, sb1_d, sb2_q, sb2_d, sb3_q, sb3_d;
  logic [CH_W-1:0]       gray_q, gray_d;
  logic [3*CH_W-1:0]     data_q, data_d;
  logic [1:0]            mode_q, mode_d;
  logic                  inv_q, inv_d;
  logic signed [CH_W:0]  ofs_q, ofs_d;
  logic [CH_W-1:0]       thr_cur_q, thr_cur_d, thr_next_q, thr_next_d;
  logic [ACC_W-1:0]      sum_q, sum_d, cnt_q, cnt_d;
  logic                  sat_frame_q, sat_frame_d, acc_sat_q, acc_sat_d;
  state_e                state_q, state_d;

  logic [SW-1:0]         w_sum;
  logic [ACC_W:0]        w_sum_inc, w_cnt_inc;
  logic                  w_sat, w_bin, w_frame_start, w_frame_end;
  logic                  w_div_start, w_div_busy, w_div_done;
  logic [ACC_W-1:0]      w_div_q;
  logic [CH_W-1:0]       w_mean, w_thr_clamp;
  logic signed [TW-1:0]  w_t;
  logic                  w_unused;

  seq_udiv #(.W(ACC_W)) u_div (
    .clk      (clk_Image_Process),
    .rst_n    (Rst),
    .start    (w_div_start),
    .dividend (sum_q),
    .divisor  (cnt_q),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_div_q)
  );

  assign w_sum     = SW'(prod_r_q) + SW'(prod_g_q) + SW'(prod_b_q);
  assign w_sum_inc = {1'b0, sum_q} + (ACC_W+1)'(gray_q);
  assign w_cnt_inc = {1'b0, cnt_q} + (ACC_W+1)'(1);
  assign w_sat     = sb2_q[VDE_BIT] & (w_sum_inc[ACC_W] | w_cnt_inc[ACC_W]);
  assign w_bin     = (gray_q > thr_cur_q) ^ inv_q;
  // Frame edges are taken at S2 so the statistics window matches the pixels counted
  assign w_frame_start = (sb2_q[VS_BIT] == VS_ACT) && (sb3_q[VS_BIT] != VS_ACT);
  assign w_frame_end   = (sb2_q[VS_BIT] != VS_ACT) && (sb3_q[VS_BIT] == VS_ACT);
  assign w_mean    = (|w_div_q[ACC_W-1:CH_W]) ? {CH_W{1'b1}} : w_div_q[CH_W-1:0];
  assign w_t       = $signed({2'b00, w_mean}) + $signed({ofs_q[CH_W], ofs_q});

  always_comb begin
    w_thr_clamp = w_t[CH_W-1:0];
    if (w_t < $signed(TW'(THR_MIN)))      w_thr_clamp = CH_W'(THR_MIN);
    else if (w_t > $signed(TW'(THR_MAX))) w_thr_clamp = CH_W'(THR_MAX);
  end

  always_comb begin
    prod_r_d    = PW'(RGB_Data_Src[3*CH_W-1 -: CH_W]) * PW'(COEF_R);
    prod_g_d    = PW'(RGB_Data_Src[2*CH_W-1 -: CH_W]) * PW'(COEF_G);
    prod_b_d    = PW'(RGB_Data_Src[CH_W-1:0]) * PW'(COEF_B);
    sb1_d       = {RGB_HSync_Src, RGB_VSync_Src, RGB_VDE_Src, RGB_x_Src, RGB_y_Src};
    gray_d      = w_sum[GRAY_SHIFT +: CH_W];
    sb2_d       = sb1_q;
    sb3_d       = sb2_q;
    data_d      = '0;
    mode_d      = mode_q;
    inv_d       = inv_q;
    ofs_d       = ofs_q;
    thr_cur_d   = thr_cur_q;
    thr_next_d  = thr_next_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    sat_frame_d = sat_frame_q;
    acc_sat_d   = acc_sat_q;
    state_d     = state_q;
    w_div_start = 1'b0;

    if (sb2_q[VDE_BIT]) begin
      data_d = (mode_q == MODE_GRAY) ? {3{gray_q}} : {(3*CH_W){w_bin}};
      sum_d  = w_sum_inc[ACC_W] ? {ACC_W{1'b1}} : w_sum_inc[ACC_W-1:0];
      cnt_d  = w_cnt_inc[ACC_W] ? {ACC_W{1'b1}} : w_cnt_inc[ACC_W-1:0];
    end
    sat_frame_d = sat_frame_q | w_sat;
    acc_sat_d   = acc_sat_q | w_sat;

    if (w_frame_start) begin
      mode_d = Mode;
      inv_d  = Invert;
      ofs_d  = Thr_Offset;
      if (Mode != MODE_ADAPT)  thr_cur_d = THR_FIX;
      else if (state_q == IDLE) thr_cur_d = thr_next_q;
    end

    if (w_frame_end) begin
      sum_d       = '0;
      cnt_d       = '0;
      sat_frame_d = 1'b0;
      acc_sat_d   = sat_frame_q | w_sat;
    end

    unique case (state_q)
      IDLE: begin
        if (w_frame_end && (cnt_q != '0)) begin
          w_div_start = 1'b1;
          state_d     = DIV;
        end
      end
      DIV:     if (w_div_done) state_d = CLAMP;
      CLAMP: begin
        thr_next_d = w_thr_clamp;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_Image_Process or negedge Rst) begin
    if (!Rst) begin
      prod_r_q    <= '0;
      prod_g_q    <= '0;
      prod_b_q    <= '0;
      sb1_q       <= SB_RST;
      sb2_q       <= SB_RST;
      sb3_q       <= SB_RST;
      gray_q      <= '0;
      data_q      <= '0;
      mode_q      <= MODE_GRAY;
      inv_q       <= 1'b0;
      ofs_q       <= '0;
      thr_cur_q   <= THR_FIX;
      thr_next_q  <= THR_FIX;
      sum_q       <= '0;
      cnt_q       <= '0;
      sat_frame_q <= 1'b0;
      acc_sat_q   <= 1'b0;
      state_q     <= IDLE;
    end else begin
      prod_r_q    <= prod_r_d;
      prod_g_q    <= prod_g_d;
      prod_b_q    <= prod_b_d;
      sb1_q       <= sb1_d;
      sb2_q       <= sb2_d;
      sb3_q       <= sb3_d;
      gray_q      <= gray_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      inv_q       <= inv_d;
      ofs_q       <= ofs_d;
      thr_cur_q   <= thr_cur_d;
      thr_next_q  <= thr_next_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      sat_frame_q <= sat_frame_d;
      acc_sat_q   <= acc_sat_d;
      state_q     <= state_d;
    end
  end

  assign w_unused   = ^{w_sum[GRAY_SHIFT-1:0], w_sum[SW-1:GRAY_SHIFT+CH_W], w_div_busy};
  assign RGB_Data   = data_q;
  assign RGB_HSync  = sb3_q[HS_BIT];
  assign RGB_VSync  = sb3_q[VS_BIT];
  assign RGB_VDE    = sb3_q[VDE_BIT];
  assign RGB_x      = sb3_q[Y_W +: X_W];
  assign RGB_y      = sb3_q[Y_W-1:0];
  assign Thresh_Cur = thr_cur_q;
  assign Acc_Sat    = acc_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_image_binarize_adaptive.sv
// ============================================================================
// tb_image_binarize_adaptive : directed bench for image_binarize_adaptive
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_image_binarize_adaptive;

  logic              clk = 1'b0;
  logic              Rst;
  logic [1:0]        Mode;
  logic              Invert;
  logic signed [8:0] Thr_Offset;
  logic [23:0]       RGB_Data_Src;
  logic              RGB_HSync_Src, RGB_VSync_Src, RGB_VDE_Src;
  logic [10:0]       RGB_x_Src;
  logic [9:0]        RGB_y_Src;
  logic [23:0]       RGB_Data;
  logic              RGB_HSync, RGB_VSync, RGB_VDE;
  logic [10:0]       RGB_x;
  logic [9:0]        RGB_y;
  logic [7:0]        Thresh_Cur;
  logic              Acc_Sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  image_binarize_adaptive dut (
    .clk_Image_Process (clk),
    .Rst               (Rst),
    .Mode              (Mode),
    .Invert            (Invert),
    .Thr_Offset        (Thr_Offset),
    .RGB_Data_Src      (RGB_Data_Src),
    .RGB_HSync_Src     (RGB_HSync_Src),
    .RGB_VSync_Src     (RGB_VSync_Src),
    .RGB_VDE_Src       (RGB_VDE_Src),
    .RGB_x_Src         (RGB_x_Src),
    .RGB_y_Src         (RGB_y_Src),
    .RGB_Data          (RGB_Data),
    .RGB_HSync         (RGB_HSync),
    .RGB_VSync         (RGB_VSync),
    .RGB_VDE           (RGB_VDE),
    .RGB_x             (RGB_x),
    .RGB_y             (RGB_y),
    .Thresh_Cur        (Thresh_Cur),
    .Acc_Sat           (Acc_Sat)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame_start();
    RGB_VSync_Src = 1'b1;
    tick(4);
  endtask

  task automatic frame_end();
    RGB_VSync_Src = 1'b0;
    tick(60);
  endtask

  // One isolated pixel: nothing at the output after 2 edges, the pixel after 3
  task automatic pixel(input string tag, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic [10:0] x, input logic [9:0] y,
                       input logic [23:0] exp);
    RGB_Data_Src  = {r, g, b};
    RGB_VDE_Src   = 1'b1;
    RGB_HSync_Src = 1'b1;
    RGB_x_Src     = x;
    RGB_y_Src     = y;
    tick(1);
    RGB_Data_Src  = '0;
    RGB_VDE_Src   = 1'b0;
    RGB_HSync_Src = 1'b0;
    RGB_x_Src     = '0;
    RGB_y_Src     = '0;
    tick(1);
    check({tag, "_lat"}, 32'(RGB_VDE), 32'd0);
    tick(1);
    check(tag, 32'(RGB_Data), 32'(exp));
    check({tag, "_sb"}, 32'({RGB_HSync, RGB_VSync, RGB_VDE, RGB_x, RGB_y}),
          32'({3'b111, x, y}));
  endtask

  task automatic ramp(input string tag, input logic [23:0] e20, input logic [23:0] e40,
                      input logic [23:0] e60, input logic [23:0] e80);
    pixel({tag, "_20"}, 8'd20, 8'd20, 8'd20, 11'd1, 10'd1, e20);
    pixel({tag, "_40"}, 8'd40, 8'd40, 8'd40, 11'd2, 10'd1, e40);
    pixel({tag, "_60"}, 8'd60, 8'd60, 8'd60, 11'd3, 10'd1, e60);
    pixel({tag, "_80"}, 8'd80, 8'd80, 8'd80, 11'd4, 10'd1, e80);
  endtask

  initial begin
    Rst           = 1'b0;
    Mode          = 2'd1;
    Invert        = 1'b0;
    Thr_Offset    = 9'sd0;
    RGB_Data_Src  = 24'hFFFFFF;
    RGB_HSync_Src = 1'b1;
    RGB_VSync_Src = 1'b1;
    RGB_VDE_Src   = 1'b1;
    RGB_x_Src     = 11'd100;
    RGB_y_Src     = 10'd50;
    tick(3);
    check("rst_data", 32'(RGB_Data), 32'd0);
    check("rst_sb", 32'({RGB_HSync, RGB_VSync, RGB_VDE, RGB_x, RGB_y}), 32'd0);
    check("rst_thr", 32'(Thresh_Cur), 32'd40);
    check("rst_sat", 32'(Acc_Sat), 32'd0);

    RGB_HSync_Src = 1'b0;
    RGB_VSync_Src = 1'b0;
    RGB_VDE_Src   = 1'b0;
    RGB_Data_Src  = '0;
    RGB_x_Src     = '0;
    RGB_y_Src     = '0;
    Rst           = 1'b1;
    tick(2);

    // Fixed threshold 40, strict compare
    frame_start();
    check("fix_thr", 32'(Thresh_Cur), 32'd40);
    pixel("fix_100", 8'd100, 8'd100, 8'd100, 11'd5, 10'd7, 24'hFFFFFF);
    pixel("fix_40",  8'd40,  8'd40,  8'd40,  11'd6, 10'd7, 24'h000000);
    pixel("fix_41",  8'd41,  8'd41,  8'd41,  11'd7, 10'd7, 24'hFFFFFF);
    frame_end();

    Invert = 1'b1;
    frame_start();
    pixel("inv_100", 8'd100, 8'd100, 8'd100, 11'd8, 10'd9, 24'h000000);
    pixel("inv_40",  8'd40,  8'd40,  8'd40,  11'd9, 10'd9, 24'hFFFFFF);
    frame_end();

    // Gray pass-through, then a mid-frame mode change that must not take effect
    Invert = 1'b0;
    Mode   = 2'd0;
    frame_start();
    pixel("gray_r", 8'd255, 8'd0,   8'd0,   11'd10, 10'd2, 24'h4C4C4C);
    pixel("gray_g", 8'd0,   8'd255, 8'd0,   11'd11, 10'd2, 24'h959595);
    pixel("gray_b", 8'd0,   8'd0,   8'd255, 11'd12, 10'd2, 24'h1C1C1C);
    pixel("gray_w", 8'd255, 8'd255, 8'd255, 11'd13, 10'd2, 24'hFFFFFF);
    Mode = 2'd1;
    pixel("gray_hold", 8'd100, 8'd100, 8'd100, 11'd14, 10'd2, 24'h646464);
    frame_end();

    frame_start();
    pixel("mode_new", 8'd100, 8'd100, 8'd100, 11'd15, 10'd3, 24'hFFFFFF);
    frame_end();

    // Adaptive: previous frame held a single gray-100 pixel with offset 0
    Mode = 2'd2;
    frame_start();
    check("adapt_first_thr", 32'(Thresh_Cur), 32'd100);
    ramp("adapt_a", 24'h0, 24'h0, 24'h0, 24'h0);
    frame_end();

    frame_start();
    check("adapt_mean50", 32'(Thresh_Cur), 32'd50);
    pixel("adapt_eq50", 8'd50, 8'd50, 8'd50, 11'd20, 10'd4, 24'h000000);
    pixel("adapt_gt50", 8'd51, 8'd51, 8'd51, 11'd21, 10'd4, 24'hFFFFFF);
    frame_end();

    frame_start();
    check("adapt_mean50b", 32'(Thresh_Cur), 32'd50);
    frame_end();

    Thr_Offset = -9'sd100;
    frame_start();
    check("empty_keep", 32'(Thresh_Cur), 32'd50);
    ramp("adapt_b", 24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF);
    frame_end();

    Thr_Offset = 9'sd250;
    frame_start();
    check("clamp_low", 32'(Thresh_Cur), 32'd16);
    ramp("adapt_c", 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    frame_end();

    Thr_Offset = 9'sd0;
    frame_start();
    check("clamp_high", 32'(Thresh_Cur), 32'd240);
    ramp("adapt_d", 24'h0, 24'h0, 24'h0, 24'h0);

    // Reset while the divider is running
    RGB_VSync_Src = 1'b0;
    tick(8);
    Rst = 1'b0;
    #1;
    check("rst_div_thr", 32'(Thresh_Cur), 32'd40);
    tick(2);
    check("rst_div_vs", 32'(RGB_VSync), 32'd0);
    Rst = 1'b1;
    tick(2);

    frame_start();
    check("post_rst_thr", 32'(Thresh_Cur), 32'd40);
    ramp("adapt_e", 24'h0, 24'h0, 24'hFFFFFF, 24'hFFFFFF);
    frame_end();

    frame_start();
    check("post_rst_mean", 32'(Thresh_Cur), 32'd50);
    pixel("post_rst_gt", 8'd51, 8'd51, 8'd51, 11'd30, 10'd5, 24'hFFFFFF);
    frame_end();
    check("no_sat", 32'(Acc_Sat), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
